// File: rtl/sram_async_ctrl.sv
// Controller for BANKS side-by-side asynchronous SRAM chips behind tristate IOBUFs.
// Read/write wait states, write pulse width and read-to-write turnaround are parameters.
module sram_async_ctrl #(
  parameter int BANKS   = 2,
  parameter int DQ_W    = 16,
  parameter int ADDR_W  = 22,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int TURN    = 1,
  localparam int DW     = BANKS * DQ_W,
  localparam int BW     = DW / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: a request transfers on a cycle where req_valid and req_ready are both 1.
  // req_ready is 1 exactly while idle; a request offered while busy is not remembered.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [BW-1:0]     req_be,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cen,
  output logic              sram_oen,
  output logic              sram_wen,
  output logic [BW-1:0]     sram_ben,
  output logic [DW-1:0]     sram_dq_o,
  output logic [DW-1:0]     sram_dq_t,
  input  logic [DW-1:0]     sram_dq_i,
  output logic [2:0]        dbg_state_o
);

  if ((DQ_W % 8) != 0 || BANKS < 1) begin : g_bad_params
    $fatal(1, "sram_async_ctrl: DQ_W must be a multiple of 8 and BANKS >= 1");
  end

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? ((RD_WAIT > TURN) ? RD_WAIT : TURN)
                                                : ((WR_WAIT > TURN) ? WR_WAIT : TURN);
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_TA   = 3'd2,
    ST_WS   = 3'd3,
    ST_WP   = 3'd4,
    ST_WH   = 3'd5
  } state_e;

  typedef struct packed {
    logic          cen;
    logic          oen;
    logic          wen;
    logic [BW-1:0] ben;
    logic          drive;
  } ctl_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [BW-1:0]     be_q, be_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  ctl_t              ctl_q, ctl_d;

  // SRAM strobes come straight from flops so WEn/OEn cannot glitch on state decode.
  function automatic ctl_t decode(input state_e s, input logic [BW-1:0] be);
    ctl_t c;
    c.cen   = 1'b1;
    c.oen   = 1'b1;
    c.wen   = 1'b1;
    c.ben   = '1;
    c.drive = 1'b0;
    unique case (s)
      ST_RD: begin
        c.cen = 1'b0;
        c.oen = 1'b0;
        c.ben = '0;
      end
      ST_WS, ST_WH: begin
        c.cen   = 1'b0;
        c.ben   = ~be;
        c.drive = 1'b1;
      end
      ST_WP: begin
        c.cen   = 1'b0;
        c.wen   = 1'b0;
        c.ben   = ~be;
        c.drive = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (req_write) begin
            state_d = ST_WS;
          end else begin
            state_d = ST_RD;
            cnt_d   = CW'(RD_WAIT);
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          rdata_d     = sram_dq_i;
          rsp_valid_d = 1'b1;
          if (TURN > 0) begin
            state_d = ST_TA;
            cnt_d   = CW'(TURN - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_TA: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_WS: begin
        state_d = ST_WP;
        cnt_d   = CW'(WR_WAIT);
      end
      ST_WP: begin
        if (cnt_q == '0) state_d = ST_WH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_WH: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    ctl_d = decode(state_d, be_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ctl_q       <= decode(ST_IDLE, '0);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ctl_q       <= ctl_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_cen    = ctl_q.cen;
  assign sram_oen    = ctl_q.oen;
  assign sram_wen    = ctl_q.wen;
  assign sram_ben    = ctl_q.ben;
  assign sram_dq_o   = wdata_q;
  assign sram_dq_t   = {DW{~ctl_q.drive}};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: default 2x16 configuration plus a 1x8 zero-wait instance.
module tb_sram_async_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- DUT A: defaults ----------------
  logic        req_valid, req_ready, req_write;
  logic [21:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [21:0] sram_addr;
  logic        sram_cen, sram_oen, sram_wen;
  logic [3:0]  sram_ben;
  logic [31:0] sram_dq_o, sram_dq_t, sram_dq_i;
  logic [2:0]  dbg_state;

  sram_async_ctrl dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_cen(sram_cen), .sram_oen(sram_oen), .sram_wen(sram_wen),
    .sram_ben(sram_ben), .sram_dq_o(sram_dq_o), .sram_dq_t(sram_dq_t), .sram_dq_i(sram_dq_i),
    .dbg_state_o(dbg_state)
  );

  // SRAM model: unwritten words come from a fixed pattern, written bytes are stored.
  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic [63:0] wr_mask = '0;
  function automatic logic [31:0] rom_val(input logic [21:0] a);
    return (a == 22'h10) ? 32'h12345678 : 32'h0BAD0000;
  endfunction
  always @(negedge clk) begin
    if (!sram_cen && !sram_wen) begin
      for (int b = 0; b < 4; b++)
        if (!sram_ben[b]) mem[sram_addr[5:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
      wr_mask[sram_addr[5:0]] <= 1'b1;
    end
  end
  assign sram_dq_i = wr_mask[sram_addr[5:0]] ? mem[sram_addr[5:0]] : rom_val(sram_addr);

  // ---------------- DUT B: 1 bank x 8, RD_WAIT=0, TURN=0 ----------------
  logic       b_req_valid, b_req_ready, b_req_write;
  logic [7:0] b_req_addr, b_req_wdata;
  logic [0:0] b_req_be;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata, b_sram_addr;
  logic       b_sram_cen, b_sram_oen, b_sram_wen;
  logic [0:0] b_sram_ben;
  logic [7:0] b_sram_dq_o, b_sram_dq_t, b_sram_dq_i;
  logic [2:0] b_dbg_state;

  sram_async_ctrl #(.BANKS(1), .DQ_W(8), .ADDR_W(8), .RD_WAIT(0), .WR_WAIT(1), .TURN(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .sram_addr(b_sram_addr), .sram_cen(b_sram_cen), .sram_oen(b_sram_oen), .sram_wen(b_sram_wen),
    .sram_ben(b_sram_ben), .sram_dq_o(b_sram_dq_o), .sram_dq_t(b_sram_dq_t),
    .sram_dq_i(b_sram_dq_i), .dbg_state_o(b_dbg_state)
  );
  assign b_sram_dq_i = {b_sram_addr[3:0], ~b_sram_addr[3:0]};

  // ---------------- control snapshots ----------------
  function automatic logic [39:0] ctl_a();
    return {sram_cen, sram_oen, sram_wen, sram_ben, sram_dq_t, req_ready};
  endfunction
  function automatic logic [39:0] mk_a(input logic cen, input logic oen, input logic wen,
                                       input logic [3:0] ben, input logic drv, input logic rdy);
    return {cen, oen, wen, ben, drv ? 32'h0 : 32'hFFFFFFFF, rdy};
  endfunction
  function automatic logic [12:0] ctl_b();
    return {b_sram_cen, b_sram_oen, b_sram_wen, b_sram_ben, b_sram_dq_t, b_req_ready};
  endfunction
  function automatic logic [12:0] mk_b(input logic cen, input logic oen, input logic wen,
                                       input logic ben, input logic drv, input logic rdy);
    return {cen, oen, wen, ben, drv ? 8'h00 : 8'hFF, rdy};
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_a_q[$];
  logic [39:0] exp_b_q[$];
  int n_rsp_a = 0;
  int bad_a = 0;
  int bad_b = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (!sram_oen && sram_dq_t != 32'hFFFFFFFF) bad_a++;
    if (rsp_valid) begin
      n_rsp_a++;
      if (exp_a_q.size() == 0) check("rsp_a_unexpected", {32'(cyc), rsp_rdata}, 64'h0);
      else begin
        e = exp_a_q.pop_front();
        check("rsp_a_cycle_data", {32'(cyc), rsp_rdata}, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [39:0] e;
    if (!b_sram_oen && b_sram_dq_t != 8'hFF) bad_b++;
    if (b_rsp_valid) begin
      if (exp_b_q.size() == 0) check("rsp_b_unexpected", {32'(cyc), b_rsp_rdata}, 64'h0);
      else begin
        e = exp_b_q.pop_front();
        check("rsp_b_cycle_data", 64'({32'(cyc), b_rsp_rdata}), 64'(e));
      end
    end
  end

  // ---------------- drivers (called just after a negedge) ----------------
  task automatic issue_a(input logic wr, input logic [21:0] a, input logic [31:0] d,
                         input logic [3:0] be, input int lat, input logic [31:0] exp_rd,
                         output int acc);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    check("accept_a", 64'(n < 40), 64'd1);
    acc = cyc;
    if (lat > 0) exp_a_q.push_back({32'(acc + lat), exp_rd});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue_b(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input logic be, input int lat, input logic [7:0] exp_rd,
                         output int acc);
    int n = 0;
    b_req_valid = 1'b1; b_req_write = wr; b_req_addr = a; b_req_wdata = d; b_req_be = be;
    while (!b_req_ready && n < 40) begin @(negedge clk); n++; end
    check("accept_b", 64'(n < 40), 64'd1);
    acc = cyc;
    if (lat > 0) exp_b_q.push_back({32'(acc + lat), exp_rd});
    @(negedge clk);
    b_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no summary after 100000 time units");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2, n0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;

    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_ctl", ctl_a(), mk_a(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1));
    check("t1_rsp_valid", {rsp_valid, b_rsp_valid}, 64'h0);
    check("t1_rdata", {rsp_rdata, b_rsp_rdata}, 64'h0);
    check("t1_addr_dqo", {sram_addr, sram_dq_o}, 64'h0);
    check("t1_state", {dbg_state, b_dbg_state}, 64'h0);
    check("t1_b_ctl", ctl_b(), mk_b(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_ready_after", req_ready, 64'h1);

    // T3 read, oen low exactly cycles 1-3, response cycle 4
    issue_a(1'b0, 22'h10, 32'h0, 4'h0, 4, 32'h12345678, acc1);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("t3_cyc%0d", k), ctl_a(),
            (k <= 3) ? mk_a(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0)
                     : mk_a(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, k == 5));
      @(negedge clk);
    end

    // T2 write with partial byte enables
    issue_a(1'b1, 22'h10, 32'hDEADBEEF, 4'b0011, 6, 32'h12345678, acc1);
    check("t2_addr_data", {sram_addr, sram_dq_o}, {22'h10, 32'hDEADBEEF});
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("t2_cyc%0d", k), ctl_a(),
            (k == 6) ? mk_a(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1)
                     : mk_a(1'b0, 1'b1, (k >= 2 && k <= 4) ? 1'b0 : 1'b1, 4'b1100, 1'b1, 1'b0));
      @(negedge clk);
    end

    // T4 read then write held valid: turnaround before the write
    issue_a(1'b0, 22'h10, 32'h0, 4'h0, 4, 32'h0000BEEF, acc1);
    issue_a(1'b1, 22'h11, 32'hCAFE0001, 4'hF, 6, 32'h0000BEEF, acc2);
    check("t4_turnaround", acc2 - acc1, 64'd5);

    // back-to-back writes then reads
    issue_a(1'b1, 22'h12, 32'h11223344, 4'hF, 6, 32'h0000BEEF, acc1);
    issue_a(1'b1, 22'h13, 32'h55667788, 4'b1001, 6, 32'h0000BEEF, acc2);
    check("b2b_write_gap", acc2 - acc1, 64'd6);
    issue_a(1'b0, 22'h13, 32'h0, 4'h0, 4, 32'h55000088, acc1);
    issue_a(1'b0, 22'h11, 32'h0, 4'h0, 4, 32'hCAFE0001, acc2);
    issue_a(1'b0, 22'h12, 32'h0, 4'h0, 4, 32'h11223344, acc1);
    check("b2b_read_gap", acc1 - acc2, 64'd5);

    // T5 reset during the write pulse
    issue_a(1'b1, 22'h14, 32'hA5A5A5A5, 4'hF, 0, 32'h0, acc1);
    @(negedge clk);
    check("t5_in_wp", ctl_a(), mk_a(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0));
    rst_n = 1'b0;
    n0 = n_rsp_a;
    @(negedge clk);
    check("t5_abort_ctl", ctl_a(), mk_a(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1));
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_no_rsp", n_rsp_a - n0, 64'd0);
    check("t5_rdata_cleared", rsp_rdata, 64'h0);
    issue_a(1'b0, 22'h11, 32'h0, 4'h0, 4, 32'hCAFE0001, acc1);

    // T6 narrow zero-wait instance
    issue_b(1'b0, 8'h03, 8'h00, 1'b0, 2, 8'h3C, acc1);
    check("t6_rd_cyc1", ctl_b(), mk_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue_b(1'b0, 8'h05, 8'h00, 1'b0, 2, 8'h5A, acc2);
    check("t6_b2b_read", acc2 - acc1, 64'd2);
    issue_b(1'b0, 8'h07, 8'h00, 1'b0, 2, 8'h78, acc1);
    check("t6_b2b_read2", acc1 - acc2, 64'd2);
    issue_b(1'b1, 8'h09, 8'h9C, 1'b1, 5, 8'h78, acc2);
    check("t6_wr_cyc1", {ctl_b(), b_sram_addr, b_sram_dq_o},
          {mk_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 8'h09, 8'h9C});

    // drain and final checks
    repeat (12) @(negedge clk);
    check("drain_a", exp_a_q.size(), 64'd0);
    check("drain_b", exp_b_q.size(), 64'd0);
    check("oen_vs_drive_a", bad_a, 64'd0);
    check("oen_vs_drive_b", bad_b, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
